clock_display_driver: RTL and testbench
=======================================

CLOCK_DISPLAY_DRIVER -- requirements
Module: clock_display_driver

Interface
REQ-001 Parameter CLK_HZ, default 100000000, input clock frequency in Hz.
REQ-002 Parameter DIGIT_HZ, default 1000, per-digit dwell rate in Hz; DIV = CLK_HZ/DIGIT_HZ cycles per digit.
REQ-003 clk  input  1  single system clock, all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 seconds  input  6  binary seconds from the seconds counter, legal 0..59.
REQ-006 minutes  input  6  binary minutes from the minutes counter, legal 0..59.
REQ-007 hours  input  5  binary hours from the hours counter, legal 0..23.
REQ-008 an  output  8  digit enables, active-low, bit k selects digit k.
REQ-009 seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-010 dp  output  1  decimal point, active-low.

Function
REQ-011 Prescaler counts 0..DIV-1 and wraps; digit_idx (3 bits) increments by 1 on the wrap cycle, 7 wraps to 0.
REQ-012 Layout: digits 5/4 = hours tens/units, 3/2 = minutes tens/units, 1/0 = seconds tens/units; digits 7/6 blank.
REQ-013 Snapshot registers capture seconds, minutes and hours together on the cycle digit_idx advances 7->0, so no frame mixes two times.
REQ-014 All digits decode from the snapshot only; input changes mid-frame have no effect until the next frame.
REQ-015 Tens = value/10, units = value%10; leading zeros shown (00:00:00 displays "000000").
REQ-016 Out-of-range field (seconds or minutes >59, hours >23) displays both digits of that field as dash (seg = 0111111, only g lit); other fields are unaffected.
REQ-017 an, seg and dp are registered; they reflect digit_idx and the snapshot with exactly one cycle of latency.
REQ-018 Exactly one an bit is low at any time after the first post-reset update; blank digits 7/6 drive their an bit low with seg = 1111111.
REQ-019 dp is low on digits 4 and 2 (HH.MM.SS separators) and high on all other digits.
REQ-020 Glyphs: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-021 DIV < 1 is illegal; elaboration fails.

Reset
REQ-022 Reset clears prescaler, digit_idx and snapshot to 0.
REQ-023 During reset and on the first cycle after it: an = 11111111, seg = 1111111, dp = 1.
REQ-024 Reset asserted mid-frame or mid-dwell takes effect on the next edge; scanning restarts at digit 0 with a full DIV dwell.
REQ-025 First snapshot after reset captures on the first 7->0 advance; digits before that show 0.

Structure
REQ-026 The glyph constants, the blank and dash patterns, and the digit-position constants are defined in a shared package, clock_disp_pkg.
REQ-027 A sub-module seg7_decode maps a 4-bit code (0-9, 10 = blank, 11 = dash) to seg; it is purely combinational.
REQ-028 Top-level integration instantiates this block downstream of the hours, minutes and seconds counters, clocked on the board clock, not clk_1Hz.

Verification (CLK_HZ=16, DIGIT_HZ=2, DIV=8)
REQ-029 Release reset; hold inputs at 0 -> each an bit is low for 8 cycles in order 0..7; digits 0-5 show "0"; the dp-low pattern repeats every 64 cycles.
REQ-030 Input hours=23, minutes=59, seconds=58, wait one frame -> digits 5..0 show 2,3,5,9,5,8; dp is low on digits 4 and 2 only.
REQ-031 Change seconds 58->59 while digit 3 is active -> digit 0 still shows 8 for the rest of the frame; 9 appears only after the next 7->0 advance.
REQ-032 Input minutes=60 and hours=24 -> digits 5-2 show dash (0111111); seconds digits stay correct.
REQ-033 Assert rst for 1 cycle while digit 4 is active -> next cycle an=11111111; then digit 0 is active for 8 cycles with snapshot 0.
REQ-034 Over 1000 random cycles: an is one-hot-low after the first update, and seg/dp always match the decoder model of the previous cycle's digit_idx.

Source files
------------

// File: rtl/clock_disp_pkg.sv
// Shared constants for the HH.MM.SS seven-segment scan driver: glyphs,
// decoder codes, digit positions and the time snapshot record.
package clock_disp_pkg;

   localparam int NUM_DIGITS = 8;
   localparam int SEG_W      = 7;

   // Segment order {g,f,e,d,c,b,a}, active-low
   localparam logic [6:0] GLYPH_0   = 7'b1000000;
   localparam logic [6:0] GLYPH_1   = 7'b1111001;
   localparam logic [6:0] GLYPH_2   = 7'b0100100;
   localparam logic [6:0] GLYPH_3   = 7'b0110000;
   localparam logic [6:0] GLYPH_4   = 7'b0011001;
   localparam logic [6:0] GLYPH_5   = 7'b0010010;
   localparam logic [6:0] GLYPH_6   = 7'b0000010;
   localparam logic [6:0] GLYPH_7   = 7'b1111000;
   localparam logic [6:0] GLYPH_8   = 7'b0000000;
   localparam logic [6:0] GLYPH_9   = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   localparam logic [3:0] CODE_BLANK = 4'd10;
   localparam logic [3:0] CODE_DASH  = 4'd11;

   localparam logic [2:0] DIG_SEC_UNITS = 3'd0;
   localparam logic [2:0] DIG_SEC_TENS  = 3'd1;
   localparam logic [2:0] DIG_MIN_UNITS = 3'd2;
   localparam logic [2:0] DIG_MIN_TENS  = 3'd3;
   localparam logic [2:0] DIG_HR_UNITS  = 3'd4;
   localparam logic [2:0] DIG_HR_TENS   = 3'd5;

   typedef struct packed {
      logic [4:0] hours;
      logic [5:0] minutes;
      logic [5:0] seconds;
   } time_snap_t;

   function automatic logic [3:0] tens_code(input logic [5:0] value, input logic valid);
      return valid ? 4'(value / 6'd10) : CODE_DASH;
   endfunction

   function automatic logic [3:0] units_code(input logic [5:0] value, input logic valid);
      return valid ? 4'(value % 6'd10) : CODE_DASH;
   endfunction

endpackage

// File: rtl/clock_display_driver_if.sv
// Time inputs from the h/m/s counters and the multiplexed display pins.
interface clock_display_driver_if;
   import clock_disp_pkg::*;

   logic [5:0]            seconds;
   logic [5:0]            minutes;
   logic [4:0]            hours;
   logic [NUM_DIGITS-1:0] an;
   logic [SEG_W-1:0]      seg;
   logic                  dp;

   modport master (output seconds, minutes, hours, input an, seg, dp);
   modport slave  (input seconds, minutes, hours, output an, seg, dp);

endinterface

// File: rtl/clock_display_driver_seg7_decode.sv
// Combinational 4-bit code to active-low segment pattern (10 = blank, 11 = dash).
module seg7_decode
   import clock_disp_pkg::*;
(
   input  logic [3:0]       code,
   output logic [SEG_W-1:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (code)
         4'd0:      seg = GLYPH_0;
         4'd1:      seg = GLYPH_1;
         4'd2:      seg = GLYPH_2;
         4'd3:      seg = GLYPH_3;
         4'd4:      seg = GLYPH_4;
         4'd5:      seg = GLYPH_5;
         4'd6:      seg = GLYPH_6;
         4'd7:      seg = GLYPH_7;
         4'd8:      seg = GLYPH_8;
         4'd9:      seg = GLYPH_9;
         CODE_DASH: seg = SEG_DASH;
         default:   seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/clock_display_driver.sv
// Eight-digit multiplexed scan of HH.MM.SS; the time is latched once per frame
// so a frame never mixes two different times.
module clock_display_driver
   import clock_disp_pkg::*;
#(
   parameter int CLK_HZ   = 100000000,
   parameter int DIGIT_HZ = 1000
) (
   input logic                   clk,
   input logic                   rst,
   clock_display_driver_if.slave disp
);

   localparam int DIV   = CLK_HZ / DIGIT_HZ;
   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DIV - 1);

   generate
      if (DIV < 1) begin : g_bad_div
         $error("clock_display_driver: CLK_HZ/DIGIT_HZ must be at least 1");
      end
   endgenerate

   logic [CNT_W-1:0] dwell_cnt;
   logic             dwell_done;
   logic [2:0]       digit_idx;
   time_snap_t       snap;
   logic             sec_ok;
   logic             min_ok;
   logic             hr_ok;
   logic [3:0]       digit_code;
   logic [SEG_W-1:0] digit_seg;

   // Dwell timer counts down; elapsed dwell cycles = DWELL_LAST - dwell_cnt
   assign dwell_done = (dwell_cnt == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         dwell_cnt <= DWELL_LAST;
         digit_idx <= 3'd0;
         snap      <= '0;
      end else if (dwell_done) begin
         dwell_cnt <= DWELL_LAST;
         digit_idx <= digit_idx + 3'd1;
         if (digit_idx == 3'd7) begin
            snap <= '{hours: disp.hours, minutes: disp.minutes, seconds: disp.seconds};
         end
      end else begin
         dwell_cnt <= dwell_cnt - CNT_W'(1);
      end
   end

   assign sec_ok = (snap.seconds <= 6'd59);
   assign min_ok = (snap.minutes <= 6'd59);
   assign hr_ok  = (snap.hours   <= 5'd23);

   always_comb begin
      digit_code = CODE_BLANK;
      case (digit_idx)
         DIG_SEC_UNITS: digit_code = units_code(snap.seconds, sec_ok);
         DIG_SEC_TENS:  digit_code = tens_code(snap.seconds, sec_ok);
         DIG_MIN_UNITS: digit_code = units_code(snap.minutes, min_ok);
         DIG_MIN_TENS:  digit_code = tens_code(snap.minutes, min_ok);
         DIG_HR_UNITS:  digit_code = units_code({1'b0, snap.hours}, hr_ok);
         DIG_HR_TENS:   digit_code = tens_code({1'b0, snap.hours}, hr_ok);
         default:       digit_code = CODE_BLANK;
      endcase
   end

   seg7_decode u_seg7_decode (
      .code (digit_code),
      .seg  (digit_seg)
   );

   // Separator dots after the hours and minutes units digits
   always_ff @(posedge clk) begin
      if (rst) begin
         disp.an  <= '1;
         disp.seg <= SEG_BLANK;
         disp.dp  <= 1'b1;
      end else begin
         disp.an  <= ~(NUM_DIGITS'(1) << digit_idx);
         disp.seg <= digit_seg;
         disp.dp  <= ~((digit_idx == DIG_MIN_UNITS) || (digit_idx == DIG_HR_UNITS));
      end
   end

endmodule

// File: tb/tb_clock_display_driver.sv
// Directed and random checks of the scan driver at CLK_HZ=16, DIGIT_HZ=2 (8-cycle dwell).
module tb_clock_display_driver;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_err    = 0;

   clock_display_driver_if disp_if ();

   clock_display_driver #(.CLK_HZ(16), .DIGIT_HZ(2)) dut (
      .clk  (clk),
      .rst  (rst),
      .disp (disp_if.slave)
   );

   always #5 clk = ~clk;

   logic [6:0] glyph [10];
   logic [6:0] exp_230 [6];
   logic [6:0] exp_dash [6];
   int         t;
   int         in_s, in_m, in_h;
   int         snap_s, snap_m, snap_h;
   int         shown_s, shown_m, shown_h;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b (t=%0d)", tag, obs, exp_v, t);
      end
   endtask

   task automatic set_in(input int h, input int m, input int s);
      in_h = h; in_m = m; in_s = s;
      disp_if.hours   = 5'(h);
      disp_if.minutes = 6'(m);
      disp_if.seconds = 6'(s);
   endtask

   // Edge-by-edge model: t counts edges since reset released, capture at every 64th edge
   task automatic tick();
      @(posedge clk);
      if (rst) begin
         t = 0;
         snap_s = 0; snap_m = 0; snap_h = 0;
         shown_s = 0; shown_m = 0; shown_h = 0;
      end else begin
         shown_s = snap_s; shown_m = snap_m; shown_h = snap_h;
         t++;
         if (t % 64 == 0) begin
            snap_s = in_s; snap_m = in_m; snap_h = in_h;
         end
      end
      #1;
   endtask

   function automatic logic [6:0] field_glyph(input int v, input int maxv, input bit tens);
      if (v > maxv) return 7'b0111111;
      return tens ? glyph[v / 10] : glyph[v % 10];
   endfunction

   function automatic logic [6:0] exp_seg(input int dig);
      case (dig)
         0: return field_glyph(shown_s, 59, 1'b0);
         1: return field_glyph(shown_s, 59, 1'b1);
         2: return field_glyph(shown_m, 59, 1'b0);
         3: return field_glyph(shown_m, 59, 1'b1);
         4: return field_glyph(shown_h, 23, 1'b0);
         5: return field_glyph(shown_h, 23, 1'b1);
         default: return 7'b1111111;
      endcase
   endfunction

   task automatic chk_model(input string tag);
      int dig;
      if (t == 0) begin
         chk({tag, "/an_off"}, disp_if.an, 8'hFF);
         chk({tag, "/seg_off"}, {1'b0, disp_if.seg}, 8'h7F);
         chk({tag, "/dp_off"}, {7'b0, disp_if.dp}, 8'h01);
      end else begin
         dig = ((t - 1) / 8) % 8;
         chk({tag, "/an"}, disp_if.an, ~(8'd1 << dig));
         chk({tag, "/seg"}, {1'b0, disp_if.seg}, {1'b0, exp_seg(dig)});
         chk({tag, "/dp"}, {7'b0, disp_if.dp}, {7'b0, ((dig == 2 || dig == 4) ? 1'b0 : 1'b1)});
      end
   endtask

   task automatic run_to(input int target, input string tag);
      int guard;
      guard = 0;
      while (t < target && guard < 2000) begin
         tick();
         chk_model(tag);
         guard++;
      end
      if (t < target) chk({tag, "/run_to_timeout"}, 8'(t), 8'(target));
   endtask

   initial begin
      logic [7:0] ones;
      glyph    = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                   7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
      exp_230  = '{7'b0000000, 7'b0010010, 7'b0010000, 7'b0010010, 7'b0110000, 7'b0100100};
      exp_dash = '{7'b1111000, 7'b1000000, 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};
      t = 0;
      rst = 1'b1;
      set_in(0, 0, 0);

      repeat (3) begin
         tick();
         chk_model("in_reset");
      end
      rst = 1'b0;
      chk_model("first_after_reset");

      run_to(1, "scan0");
      chk("d0_first_an", disp_if.an, 8'hFE);
      chk("d0_first_seg", {1'b0, disp_if.seg}, 8'b01000000);
      run_to(8, "scan0");
      chk("d0_last_an", disp_if.an, 8'hFE);
      run_to(9, "scan0");
      chk("d1_first_an", disp_if.an, 8'hFD);
      run_to(33, "scan0");
      chk("d4_dp", {7'b0, disp_if.dp}, 8'h00);
      run_to(41, "scan0");
      chk("d5_dp", {7'b0, disp_if.dp}, 8'h01);
      run_to(64, "scan0");

      set_in(23, 59, 58);
      run_to(128, "pre_235958");
      for (int d = 0; d < 6; d++) begin
         run_to(129 + 8 * d, "frame_235958");
         chk("hand_235958_seg", {1'b0, disp_if.seg}, {1'b0, exp_230[d]});
         chk("hand_235958_dp", {7'b0, disp_if.dp}, {7'b0, ((d == 2 || d == 4) ? 1'b0 : 1'b1)});
      end

      run_to(218, "frame_change");
      set_in(23, 59, 59);
      run_to(256, "frame_change");
      run_to(257, "frame_59");
      chk("sec_59_shown", {1'b0, disp_if.seg}, 8'b00010000);
      run_to(258, "frame_59");
      set_in(23, 59, 7);
      run_to(264, "frame_hold");
      chk("d0_holds_9", {1'b0, disp_if.seg}, 8'b00010000);
      run_to(265, "frame_hold");
      chk("d1_holds_5", {1'b0, disp_if.seg}, 8'b00010010);
      run_to(321, "frame_07");
      chk("sec_07_units", {1'b0, disp_if.seg}, 8'b01111000);
      run_to(322, "frame_07");
      set_in(24, 60, 7);
      run_to(329, "frame_07");
      chk("sec_07_tens", {1'b0, disp_if.seg}, 8'b01000000);

      run_to(384, "pre_dash");
      for (int d = 0; d < 6; d++) begin
         run_to(385 + 8 * d, "frame_dash");
         chk("hand_dash_seg", {1'b0, disp_if.seg}, {1'b0, exp_dash[d]});
      end

      run_to(481, "pre_midreset");
      chk("d4_active", disp_if.an, 8'hEF);
      run_to(483, "pre_midreset");
      rst = 1'b1;
      tick();
      chk_model("midreset");
      chk("midreset_an", disp_if.an, 8'hFF);
      rst = 1'b0;
      chk_model("midreset_release");
      for (int k = 1; k <= 8; k++) begin
         tick();
         chk_model("after_midreset");
         chk("restart_d0_an", disp_if.an, 8'hFE);
         chk("restart_d0_seg", {1'b0, disp_if.seg}, 8'b01000000);
      end
      tick();
      chk("restart_d1_an", disp_if.an, 8'hFD);

      for (int k = 0; k < 1000; k++) begin
         set_in(int'($urandom_range(31, 0)), int'($urandom_range(63, 0)), int'($urandom_range(63, 0)));
         tick();
         chk_model("random");
         ones = 8'($countones(~disp_if.an));
         chk("random_onehot", ones, 8'd1);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
